// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Wrap-around priority search: first set req bit at or above ptr, wrapping past N-1 to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter feeding one synchronous FIFO write port, zero-latency grants.
// Define FIFO_WR_ARB_BURST_EN to let an owner keep the port for up to BURST_LEN writes.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in
);

    localparam int PW = cnt_w(NUM_REQ);
    localparam int CW = cnt_w(BURST_LEN + 1);
`ifdef FIFO_WR_ARB_BURST_EN
    localparam bit BURST_ON = (BURST_LEN > 1);
`else
    localparam bit BURST_ON = 1'b0;
`endif

    arb_state_t   state, state_nxt;
    logic [PW-1:0] rr_ptr, rr_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PW-1:0]      pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] gnt_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + PW'(1);
    endfunction

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // A full FIFO freezes everything: no grant, no state movement.
    always_comb begin
        gnt_c     = '0;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        if (!fifo_full) begin
            case (state)
                ARB: begin
                    if (pick_found) begin
                        gnt_c = pick_oh;
                        if (BURST_ON) begin
                            owner_nxt = pick_idx;
                            cnt_nxt   = CW'(1);
                            state_nxt = LOCK;
                        end else begin
                            rr_nxt = ptr_inc(pick_idx);
                        end
                    end
                end
                LOCK: begin
                    if (req[owner]) begin
                        gnt_c[owner] = 1'b1;
                        if (cnt == CW'(BURST_LEN - 1)) begin
                            state_nxt = ARB;
                            cnt_nxt   = '0;
                            rr_nxt    = ptr_inc(owner);
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        state_nxt = ARB;
                        cnt_nxt   = '0;
                        rr_nxt    = ptr_inc(owner);
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB;
            rr_ptr <= '0;
            owner  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            owner  <= owner_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Reset gates the combinational path so outputs drop the instant rst falls.
    assign gnt = rst ? gnt_c : '0;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] masked;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign masked[i] = gnt[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) fifo_data_in = fifo_data_in | masked[i];
    end

    assign fifo_wr_en = |gnt;
    assign fifo_wr_cs = |gnt;

endmodule
